// File: rtl/seven_seg_scan_n_if.sv
// Write port into the digit register file of seven_seg_scan_n.
// The host drives the bus (master) and the scan controller samples it (slave).
interface seven_seg_scan_n_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [4:0]    wr_code;
  logic          wr_dp;
  logic          wr_blink;

  modport master (output wr_en, wr_addr, wr_code, wr_dp, wr_blink);
  modport slave  (input  wr_en, wr_addr, wr_code, wr_dp, wr_blink);
endinterface

// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment controller.
// Holds a {blink, dp, code} entry per digit, scans the digits one slot at a
// time on active-low anodes, applies PWM brightness within each slot, blinks
// selected digits on a frame-count half period, and keeps the anodes dark for
// the first cycle of every slot so the previous digit never ghosts into the next.
module seven_seg_scan_n #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int REFRESH_CNT = 200_000,
  parameter  int BLINK_DIV   = 64,
  localparam int AW          = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_scan_n_if.slave     wr,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [AW-1:0]         scan_idx,
  output logic                  frame_tick
);

  localparam int CW = $clog2(REFRESH_CNT);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_CNT - 1);
  localparam logic [AW-1:0] DIGIT_LAST = AW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  typedef struct packed {
    logic       blink;
    logic       dp;
    logic [4:0] code;
  } entry_t;

  // Code 23 decodes to blank, so a freshly reset display is dark.
  localparam entry_t ENTRY_BLANK = '{blink: 1'b0, dp: 1'b0, code: 5'd23};

  entry_t        rf [NUM_DIGITS];
  logic [CW-1:0] slot_cnt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic          slot_wrap;
  logic          frame_wrap;
  logic          wr_in_range;
  entry_t        cur;
  logic          an_en;
  logic [7:0]    seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Glyph table, active-low, bit order g..a.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] g;
    g = 7'b1111111;
    case (code)
      5'd0:  g = 7'b1000000;
      5'd1:  g = 7'b1111001;
      5'd2:  g = 7'b0100100;
      5'd3:  g = 7'b0110000;
      5'd4:  g = 7'b0011001;
      5'd5:  g = 7'b0010010;
      5'd6:  g = 7'b0000010;
      5'd7:  g = 7'b1111000;
      5'd8:  g = 7'b0000000;
      5'd9:  g = 7'b0010000;
      5'd10: g = 7'b0001000; // A
      5'd11: g = 7'b0000011; // b
      5'd12: g = 7'b1000110; // C
      5'd13: g = 7'b0100001; // d
      5'd14: g = 7'b0000110; // E
      5'd15: g = 7'b0001110; // F
      5'd16: g = 7'b1111110; // segment a alone
      5'd17: g = 7'b1111101;
      5'd18: g = 7'b1111011;
      5'd19: g = 7'b1110111;
      5'd20: g = 7'b1101111;
      5'd21: g = 7'b1011111;
      5'd22: g = 7'b0111111; // segment g alone
      5'd24: g = 7'b0001001; // H
      5'd25: g = 7'b1000111; // L
      5'd26: g = 7'b0001000; // R
      5'd27: g = 7'b1001111; // l
      5'd28: g = 7'b0101111; // r
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (scan_idx == DIGIT_LAST);

  // Non-power-of-two digit counts leave addresses that map to no entry.
  assign wr_in_range = ((AW + 1)'(wr.wr_addr) < (AW + 1)'(NUM_DIGITS));

  // Slot timer and digit pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      scan_idx <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      scan_idx <= (scan_idx == DIGIT_LAST) ? '0 : scan_idx + AW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  // Frame counter; blink phase flips when a full blink half-period of frames completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Pulse for the first cycle of each frame (scan back on digit 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= frame_wrap;
  end

  // Digit register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) rf[i] <= ENTRY_BLANK;
    end else if (wr.wr_en && wr_in_range) begin
      rf[wr.wr_addr] <= '{blink: wr.wr_blink, dp: wr.wr_dp, code: wr.wr_code};
    end
  end

  // Next cathode/anode pattern from the current scan state.
  always_comb begin
    cur   = rf[scan_idx];
    seg_d = 8'hFF;
    an_d  = '1;
    // A blinking digit in its dark phase loses its dp as well.
    if (!(cur.blink && blink_phase)) seg_d = {~cur.dp, decode(cur.code)};
    // Slot cycle 0 is dead time; the low nibble of the slot timer is the PWM ramp.
    an_en = (slot_cnt != '0) &&
            ((brightness == 4'hF) || (slot_cnt[3:0] < brightness));
    if (an_en) an_d[scan_idx] = 1'b0;
  end

  // Registered drivers so seg and an always move on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Randomized bench for seven_seg_scan_n against a cycle-count based display model.
module tb_seven_seg_scan_n;

  localparam int N  = 4;
  localparam int R  = 16;
  localparam int B  = 2;
  localparam int N5 = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] brightness;

  logic [7:0]   seg;
  logic [N-1:0] an;
  logic [1:0]   scan_idx;
  logic         frame_tick;

  logic [7:0]    seg5;
  logic [N5-1:0] an5;
  logic [2:0]    idx5;
  logic          ft5;

  seven_seg_scan_n_if #(.NUM_DIGITS(N))  wif  ();
  seven_seg_scan_n_if #(.NUM_DIGITS(N5)) wif5 ();

  seven_seg_scan_n #(.NUM_DIGITS(N), .REFRESH_CNT(R), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset), .wr(wif.slave), .brightness(brightness),
    .seg(seg), .an(an), .scan_idx(scan_idx), .frame_tick(frame_tick));

  // Five digits leave addresses 5..7 unmapped, exercising the write guard.
  seven_seg_scan_n #(.NUM_DIGITS(N5), .REFRESH_CNT(R), .BLINK_DIV(1)) dut5 (
    .clk(clk), .reset(reset), .wr(wif5.slave), .brightness(brightness),
    .seg(seg5), .an(an5), .scan_idx(idx5), .frame_tick(ft5));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model: n = edges since reset release; display entries per digit.
  int n;
  int m_code [N];
  bit m_dp   [N];
  bit m_blk  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  // Segment pattern built from the list of lit segments of each glyph.
  function automatic logic [6:0] glyph(input int code);
    string s;
    logic [6:0] b;
    b = 7'h7F;
    s = "";
    case (code)
      0: s = "abcdef";   1: s = "bc";      2: s = "abdeg";   3: s = "abcdg";
      4: s = "bcfg";     5: s = "acdfg";   6: s = "acdefg";  7: s = "abc";
      8: s = "abcdefg";  9: s = "abcdfg";  10: s = "abcefg"; 11: s = "cdefg";
      12: s = "adef";    13: s = "bcdeg";  14: s = "adefg";  15: s = "aefg";
      24: s = "bcefg";   25: s = "def";    26: s = "abcefg"; 27: s = "ef";
      28: s = "eg";
      default: s = "";
    endcase
    if (code >= 16 && code <= 22) b[code - 16] = 1'b0;
    for (int i = 0; i < s.len(); i++) b[s[i] - 8'h61] = 1'b0;
    return b;
  endfunction

  task automatic model_clear();
    n = 0;
    for (int i = 0; i < N; i++) begin
      m_code[i] = 23; m_dp[i] = 1'b0; m_blk[i] = 1'b0;
    end
  endtask

  // One clock: predict outputs from the state after n edges, then compare.
  task automatic tick();
    int p, d, f, ph, bri;
    logic [7:0] seg_e;
    logic [N-1:0] an_e;
    bit on;
    p   = n % R;
    d   = (n / R) % N;
    f   = n / (R * N);
    ph  = (f / B) % 2;
    bri = int'(brightness);
    if (m_blk[d] && ph == 1) seg_e = 8'hFF;
    else                     seg_e = {~m_dp[d], glyph(m_code[d])};
    on   = (p != 0) && (bri == 15 || (p % 16) < bri);
    an_e = '1;
    if (on) an_e[d] = 1'b0;
    @(posedge clk);
    #1;
    n++;
    if (wif.wr_en && int'(wif.wr_addr) < N) begin
      m_code[wif.wr_addr] = int'(wif.wr_code);
      m_dp[wif.wr_addr]   = wif.wr_dp;
      m_blk[wif.wr_addr]  = wif.wr_blink;
    end
    chk("seg", seg, seg_e);
    chk("an", an, an_e);
    chk("scan_idx", scan_idx, (n / R) % N);
    chk("frame_tick", frame_tick, (n % (R * N)) == 0);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic wr_main(input int a, input int c, input bit dp, input bit bl);
    wif.wr_en = 1'b1; wif.wr_addr = 2'(a); wif.wr_code = 5'(c);
    wif.wr_dp = dp;   wif.wr_blink = bl;
    tick();
    wif.wr_en = 1'b0;
  endtask

  task automatic wr_five(input int a, input int c, input bit dp);
    wif5.wr_en = 1'b1; wif5.wr_addr = 3'(a); wif5.wr_code = 5'(c);
    wif5.wr_dp = dp;   wif5.wr_blink = 1'b0;
    tick();
    wif5.wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, seg, 8'hFF);
    chk({tag, "_an"}, an, {N{1'b1}});
    chk({tag, "_idx"}, scan_idx, 0);
    chk({tag, "_ft"}, frame_tick, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  int dec_codes [N] = '{0, 10, 24, 31};
  bit found;

  initial begin
    reset = 1'b1;
    brightness = 4'hF;
    wif.wr_en = 0;  wif.wr_addr = 0;  wif.wr_code = 0;  wif.wr_dp = 0;  wif.wr_blink = 0;
    wif5.wr_en = 0; wif5.wr_addr = 0; wif5.wr_code = 0; wif5.wr_dp = 0; wif5.wr_blink = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    release_reset();

    // Blank scan with full brightness: dead cycle per slot, frame_tick every 64.
    run(2 * R * N);

    // Decode sample with dp lit.
    for (int i = 0; i < N; i++) wr_main(i, dec_codes[i], 1'b1, 1'b0);
    run(2 * R * N);

    // Write to digit 0 while it is on display; new glyph one edge later.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((n / R) % N == 0 && n % R == 5) found = 1;
      else tick();
    end
    chk("find_d0", found, 1);
    wr_main(0, 8, 1'b0, 1'b0);
    tick();
    chk("wr_latency", seg, 8'h80);

    // PWM: 4/16 then off.
    brightness = 4'd4;
    run(R * N);
    brightness = 4'd0;
    run(R * N);
    brightness = 4'hF;

    // Blink on digit 2.
    wr_main(2, 7, 1'b0, 1'b1);
    run(5 * R * N);

    // Random writes and brightness changes.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)
        wr_main($urandom_range(0, N - 1), $urandom_range(0, 31),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      else
        tick();
    end
    brightness = 4'hF;

    // Unmapped addresses on the five-digit instance must not land anywhere.
    for (int a = 5; a < 8; a++) wr_five(a, 8, 1'b1);
    for (int i = 0; i < R * N5 + 4; i++) begin
      tick();
      chk("guard_seg", seg5, 8'hFF);
    end
    wr_five(4, 8, 1'b1);
    found = 0;
    for (int i = 0; i < R * N5 + 4; i++) begin
      tick();
      if (seg5 == 8'h00) found = 1;
    end
    chk("guard_hit", found, 1);

    // Asynchronous reset mid-slot at digit 2, slot 9.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((n / R) % N == 2 && n % R == 9) found = 1;
      else tick();
    end
    chk("find_d2s9", found, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("arst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("arst_hold");
    release_reset();
    run(2 * R * N);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
